// File: rtl/cube_if.sv
// Operand/result bus of the cube unit: start request with operand in,
// busy flag and cubed result out.
interface cube_if #(
  parameter int unsigned N = 8
);
  logic [N-1:0]   x_bi;
  logic           start_i;
  logic           busy_o;
  logic [3*N-1:0] y_bo;

  modport master (output x_bi, output start_i, input busy_o, input y_bo);
  modport slave  (input x_bi, input start_i, output busy_o, output y_bo);
endinterface

// File: rtl/cube.sv
// Sequential unsigned cube y = x^3 using two back-to-back shift-add multiplies,
// one multiplier bit per clock, N clocks each (2N clocks busy per operation).
module cube #(
  parameter int unsigned N = 8
) (
  input  logic  clk_i,
  input  logic  rst_i,
  cube_if.slave bus
);
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL1 = 2'd1,
    MUL2 = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   x_q, x_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic [3*N-1:0] mcand_q, mcand_d;
  logic [3*N-1:0] acc_q, acc_d;
  logic [3*N-1:0] y_q, y_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic [3*N-1:0] sum;
  logic           last;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      x_q      <= '0;
      mplier_q <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      y_q      <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      mplier_q <= mplier_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      y_q      <= y_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    mplier_d = mplier_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    y_d      = y_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    // One partial-product step: add the shifted multiplicand when the current
    // multiplier LSB is set; the multiplier shifts right instead of indexing by cnt.
    sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
    last = (cnt_q == CW'(N - 1));

    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          x_d      = bus.x_bi;
          mplier_d = bus.x_bi;
          mcand_d  = {{(2 * N){1'b0}}, bus.x_bi};
          acc_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = MUL1;
        end
      end
      MUL1: begin
        acc_d    = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (last) begin
          // x^2 fits in 2N bits and becomes the multiplicand for the second pass
          mcand_d  = {{N{1'b0}}, sum[2*N-1:0]};
          mplier_d = x_q;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = MUL2;
        end
      end
      MUL2: begin
        acc_d    = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (last) begin
          y_d     = sum;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.busy_o = busy_q;
  assign bus.y_bo   = y_q;
endmodule

// File: tb/tb_cube.sv
// Directed, table-driven bench for cube (N = 8) plus multi-cycle corner sequences.
module tb_cube;
  localparam int unsigned N = 8;

  typedef struct {
    logic [N-1:0]   x;
    logic [3*N-1:0] y;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  cube_if #(.N(N)) bus ();

  cube #(.N(N)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait until busy drops; counts edges from now. Expired bound returns 999.
  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (bus.busy_o === 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    if (cyc >= 100) cyc = 999;
  endtask

  // Called idle, just after a rising edge. Pulses start, scrambles x after E0.
  task automatic run_one(input logic [N-1:0] x, input logic [3*N-1:0] exp, input string name);
    logic [3*N-1:0] y0;
    int cyc;
    logic held;
    y0 = bus.y_bo;
    bus.x_bi    = x;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    bus.x_bi    = ~x;
    cyc  = 0;
    held = 1'b1;
    while (bus.busy_o === 1'b1 && cyc < 100) begin
      if (bus.y_bo !== y0) held = 1'b0;
      tick();
      cyc++;
    end
    check({name, " busy_cycles"}, cyc, 16);
    check({name, " y_hold"}, {31'd0, held}, 32'd1);
    check({name, " y"}, {8'd0, bus.y_bo}, {8'd0, exp});
  endtask

  vec_t vecs[10];

  initial begin
    int cyc;
    logic [3*N-1:0] e;
    checks = 0;
    errors = 0;
    vecs[0] = '{x: 8'd16,  y: 24'd4096};
    vecs[1] = '{x: 8'd0,   y: 24'd0};
    vecs[2] = '{x: 8'd1,   y: 24'd1};
    vecs[3] = '{x: 8'd255, y: 24'hFD02FF};
    vecs[4] = '{x: 8'd3,   y: 24'd27};
    vecs[5] = '{x: 8'd2,   y: 24'd8};
    vecs[6] = '{x: 8'd5,   y: 24'd125};
    vecs[7] = '{x: 8'd10,  y: 24'd1000};
    vecs[8] = '{x: 8'd100, y: 24'd1000000};
    vecs[9] = '{x: 8'd128, y: 24'd2097152};

    rst = 1'b0;
    bus.start_i = 1'b1;
    bus.x_bi = 8'd9;
    repeat (2) tick();
    check("reset busy", {31'd0, bus.busy_o}, 32'd0);
    check("reset y", {8'd0, bus.y_bo}, 32'd0);
    bus.start_i = 1'b0;
    rst = 1'b1;
    tick();

    for (int unsigned i = 0; i < 10; i++)
      run_one(vecs[i].x, vecs[i].y, $sformatf("vec%0d", i));

    // start during busy is ignored
    bus.x_bi = 8'd3;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    repeat (4) tick();
    bus.x_bi = 8'd7;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    wait_idle(cyc);
    check("busy_ignore cycles", cyc, 11);
    check("busy_ignore y", {8'd0, bus.y_bo}, 32'd27);
    tick();
    check("busy_ignore no_restart", {31'd0, bus.busy_o}, 32'd0);

    // back-to-back with start held; operand changed mid-run is picked up next time
    bus.x_bi = 8'd2;
    bus.start_i = 1'b1;
    tick();
    bus.x_bi = 8'd9;
    wait_idle(cyc);
    check("b2b first cycles", cyc, 16);
    check("b2b first y", {8'd0, bus.y_bo}, 32'd8);
    tick();
    check("b2b low_one_cycle", {31'd0, bus.busy_o}, 32'd1);
    bus.start_i = 1'b0;
    wait_idle(cyc);
    check("b2b second cycles", cyc, 16);
    check("b2b second y", {8'd0, bus.y_bo}, 32'd729);
    tick();

    // reset mid-operation
    run_one(8'd2, 24'd8, "pre_reset");
    bus.x_bi = 8'd5;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    repeat (6) tick();
    rst = 1'b0;
    #1;
    check("midreset busy", {31'd0, bus.busy_o}, 32'd0);
    check("midreset y", {8'd0, bus.y_bo}, 32'd0);
    bus.start_i = 1'b1;
    tick();
    check("start_in_reset busy", {31'd0, bus.busy_o}, 32'd0);
    rst = 1'b1;
    bus.start_i = 1'b0;
    run_one(8'd5, 24'd125, "after_reset");

    // full operand sweep against an arithmetic reference
    for (int unsigned v = 0; v < 256; v++) begin
      e = 24'(v * v * v);
      run_one(8'(v), e, $sformatf("sweep%0d", v));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cube.md
CUBE -- requirements
Module: cube

Interface
REQ-001 SHALL have parameter N, default 8, giving the operand width in bits.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, reset that is asynchronous and active-low (0 = reset).
REQ-004 SHALL have port x_bi, input, N, unsigned operand, sampled only when a start is accepted.
REQ-005 SHALL have port start_i, input, 1, request to begin one cube computation.
REQ-006 SHALL have port busy_o, output, 1, high while a computation is in progress.
REQ-007 SHALL have port y_bo, output, 3N, unsigned result x^3 of the last completed computation.

Function
REQ-008 SHALL compute y = x*x*x exactly, unsigned, with no truncation; 3N bits always hold the result (255^3 = 16581375 for N=8).
REQ-009 SHALL use an FSM with states IDLE, MUL1 (x*x), MUL2 (x^2*x); no other reachable states.
REQ-010 SHALL perform each multiply as iterative shift-add, one multiplier bit per cycle, N cycles per multiply; no combinational N x N or wider multiplier.
REQ-011 SHALL accept a start only on a rising edge where state = IDLE and start_i = 1: latch x_bi, clear the partial product, clear the bit counter, set busy_o = 1, and go to MUL1 (edge E0).
REQ-012 SHALL stay in MUL1 for edges E1..EN, then move to MUL2 holding x^2 (2N bits) as the multiplicand source.
REQ-013 SHALL stay in MUL2 for edges EN+1..E2N; on E2N load y_bo with the final product, set busy_o = 0, and return to IDLE.
REQ-014 SHALL keep busy_o high for exactly 2N clock periods per computation (16 for N=8).
REQ-015 SHALL hold y_bo at its previous value throughout a computation; y_bo changes only on E2N or on reset.
REQ-016 SHALL ignore start_i while busy_o = 1; no restart, no queuing.
REQ-017 SHALL ignore changes on x_bi after E0 until the computation completes.
REQ-018 SHALL, when start_i is held high continuously, accept the next start on the edge after E2N, so busy_o is low for exactly one cycle between operations.
REQ-019 SHALL handle x = 0 and x = 1 with the same 2N-cycle latency as any other operand; no early termination.
REQ-020 SHALL keep the internal bit counter wide enough to count to N-1 without wrap-around in any state.

Reset
REQ-021 SHALL, while rst_i = 0, force state = IDLE, busy_o = 0, y_bo = 0, and clear all internal registers, independent of clk_i.
REQ-022 SHALL, on reset asserted mid-computation, abort the operation immediately; no partial result reaches y_bo.
REQ-023 SHALL not accept a start on any edge where rst_i = 0; the first start can be accepted on the first rising edge with rst_i = 1.

Verification
REQ-024 SHALL verify basic operation: after reset, x_bi = 16, start_i pulsed for one cycle -> busy_o high 16 cycles, then y_bo = 4096, busy_o = 0.
REQ-025 SHALL verify boundaries: x_bi = 0 -> y_bo = 0; x_bi = 1 -> 1; x_bi = 255 -> 16581375 (0xFD02FF); each with a 16-cycle busy_o pulse.
REQ-026 SHALL verify busy behaviour: x_bi = 3 started, then start_i = 1 with x_bi = 7 at cycle 5 -> ignored; y_bo = 27 at completion.
REQ-027 SHALL verify back-to-back operation: start_i held high, x_bi = 2 -> y_bo = 8, busy_o low exactly 1 cycle, next result computed from the x_bi sampled then.
REQ-028 SHALL verify reset mid-operation: previous y_bo = 8, start x_bi = 5, rst_i = 0 at cycle 7 -> y_bo = 0, busy_o = 0 immediately; after release, x_bi = 5 restart -> y_bo = 125.
REQ-029 SHALL verify with a self-checking bench that compares y_bo against x^3 for all 256 operand values.
